// File: rtl/bus_grant_arbiter8.sv
// Round-robin arbiter for 8 requesters with hold limiting,
// a one-cycle release gap and an enable gate.
module bus_grant_arbiter8 #(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] req,
    output logic [7:0] grant_n,
    output logic [2:0] grant_id,
    output logic       grant_valid,
    output logic       preempt
);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        RELEASE
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0] HOLD_TOP =
        (MAX_HOLD == 0) ? {CNT_W{1'b1}} : HOLD_LIM;

    state_t           state, state_nxt;
    logic [2:0]       ptr, ptr_nxt;
    logic [CNT_W-1:0] hold_cnt, hold_nxt;
    logic [7:0]       grant_n_nxt;
    logic [2:0]       grant_id_nxt;
    logic             grant_valid_nxt;
    logic             preempt_nxt;
    logic [2:0]       pick_id;
    logic             pick_ok;
    logic             timeout;
    logic             release_now;

    // First requester after the last grantee, wrapping mod 8.
    always_comb begin
        pick_id = '0;
        pick_ok = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            if (!pick_ok && req[ptr + 3'(i)]) begin
                pick_ok = 1'b1;
                pick_id = ptr + 3'(i);
            end
        end
    end

    assign timeout     = (MAX_HOLD != 0) && (hold_cnt == HOLD_LIM);
    assign release_now = !req[grant_id] || !en || timeout;

    // Next-state and next-output decode for the tenure FSM.
    always_comb begin
        state_nxt       = state;
        ptr_nxt         = ptr;
        hold_nxt        = hold_cnt;
        grant_n_nxt     = grant_n;
        grant_id_nxt    = grant_id;
        grant_valid_nxt = grant_valid;
        preempt_nxt     = 1'b0;
        unique case (state)
            IDLE: begin
                if (en && pick_ok) begin
                    state_nxt       = GRANT;
                    grant_n_nxt     = ~(8'h01 << pick_id);
                    grant_id_nxt    = pick_id;
                    grant_valid_nxt = 1'b1;
                    hold_nxt        = CNT_W'(1);
                end else begin
                    grant_n_nxt     = 8'hFF;
                    grant_valid_nxt = 1'b0;
                end
            end
            GRANT: begin
                if (release_now) begin
                    state_nxt       = RELEASE;
                    ptr_nxt         = grant_id;
                    grant_n_nxt     = 8'hFF;
                    grant_valid_nxt = 1'b0;
                    hold_nxt        = '0;
                    preempt_nxt     = timeout && req[grant_id] && en;
                end else if (hold_cnt != HOLD_TOP) begin
                    hold_nxt = hold_cnt + CNT_W'(1);
                end
            end
            RELEASE: begin
                state_nxt       = IDLE;
                grant_n_nxt     = 8'hFF;
                grant_valid_nxt = 1'b0;
            end
            default: begin
                state_nxt       = IDLE;
                grant_n_nxt     = 8'hFF;
                grant_valid_nxt = 1'b0;
            end
        endcase
    end

    // State, pointer, hold counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= 3'd7;
            hold_cnt    <= '0;
            grant_n     <= 8'hFF;
            grant_id    <= 3'd0;
            grant_valid <= 1'b0;
            preempt     <= 1'b0;
        end else begin
            state       <= state_nxt;
            ptr         <= ptr_nxt;
            hold_cnt    <= hold_nxt;
            grant_n     <= grant_n_nxt;
            grant_id    <= grant_id_nxt;
            grant_valid <= grant_valid_nxt;
            preempt     <= preempt_nxt;
        end
    end

endmodule
